seven_seg_capture: RTL and testbench

- Receive-side counterpart of the four-digit multiplexed seven-segment driver.
- Samples segment lines a..g and the active-low digit enables n3..n0, waits for each pattern to stay stable, and decodes it to a 4-bit hex value.
- Stores the value in a per-digit register and flags each completed four-digit frame.
- Used as a loopback checker and as a display-readback monitor on the board.

---
 rtl/seven_seg_capture.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_capture.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Receive side of a four-digit multiplexed seven-segment display. Samples the
//   segment lines and active-low digit enables, and waits for each pattern to
//   stay stable. It then decodes the pattern to a hex value and stores it in the
//   register of the enabled digit. A one-cycle pulse flags each completed
//   four-digit frame.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a..g                      segment lines (async to clk)
//   n3..n0                    active-low digit enables (async to clk)
//   digit0..digit3 [3:0]      last captured value for enable n0..n3
//   digit_valid [3:0]         bit i set once digit i captured since reset
//   frame_done                one-cycle pulse per completed four-digit frame
//   err                       sticky: illegal pattern or multiple enables low
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       n3,
    input  logic       n2,
    input  logic       n1,
    input  logic       n0,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       err
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    // The edge that sees the Nth identical sample has cnt == N-2. The first
    // sample of a new pattern is the one that resets cnt.
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

    // {legal, value} for a lit-high abcdefg pattern
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = {1'b1, 4'h0};
            7'b0110000: decode = {1'b1, 4'h1};
            7'b1101101: decode = {1'b1, 4'h2};
            7'b1111001: decode = {1'b1, 4'h3};
            7'b0110011: decode = {1'b1, 4'h4};
            7'b1011011: decode = {1'b1, 4'h5};
            7'b1011111: decode = {1'b1, 4'h6};
            7'b1110000: decode = {1'b1, 4'h7};
            7'b1111111: decode = {1'b1, 4'h8};
            7'b1111011: decode = {1'b1, 4'h9};
            7'b1110111: decode = {1'b1, 4'hA};
            7'b0011111: decode = {1'b1, 4'hB};
            7'b1001110: decode = {1'b1, 4'hC};
            7'b0111101: decode = {1'b1, 4'hD};
            7'b1001111: decode = {1'b1, 4'hE};
            7'b1000111: decode = {1'b1, 4'hF};
            default:    decode = 5'b0;
        endcase
    endfunction

    logic [10:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]        svld_q, svld_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              accepted_q, accepted_d;
    logic [3:0][3:0]   digit_q, digit_d;
    logic [3:0]        dvalid_q, dvalid_d, seen_q, seen_d;
    logic              frame_q, frame_d, err_q, err_d;

    logic [6:0]        seg;
    logic [3:0]        en;
    logic [4:0]        dec;
    logic              same, stable_ev, one_hot;

    always_comb begin
        sync1_d    = {a, b, c, d, e, f, g, n3, n2, n1, n0};
        sync2_d    = sync1_q;
        // Marks when the synchronizer holds real input rather than reset zeros,
        // so the flushed all-zero sample can never be mistaken for a pattern.
        svld_d     = {svld_q[0], 1'b1};
        prev_d     = sync2_q;

        seg        = SEG_ACTIVE_LOW ? ~sync2_q[10:4] : sync2_q[10:4];
        en         = ~sync2_q[3:0];
        dec        = decode(seg);
        one_hot    = (en != 4'b0) && ((en & (en - 4'd1)) == 4'b0);

        same       = svld_q[1] && (sync2_q == prev_q);
        stable_ev  = same && (cnt_q == CNT_FIRE) && !accepted_q;

        cnt_d      = cnt_q;
        accepted_d = accepted_q;
        if (!same) begin
            cnt_d      = '0;
            accepted_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d      = cnt_q + 1'b1;
        end
        if (stable_ev) accepted_d = 1'b1;

        digit_d    = digit_q;
        dvalid_d   = dvalid_q;
        err_d      = err_q;
        frame_d    = (seen_q == 4'hF);
        // Clear happens first so a capture on the same edge survives.
        seen_d     = (seen_q == 4'hF) ? 4'h0 : seen_q;

        if (stable_ev && en != 4'b0) begin
            if (!one_hot || !dec[4]) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (en[i]) begin
                        digit_d[i]  = dec[3:0];
                        dvalid_d[i] = 1'b1;
                        seen_d[i]   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            svld_q     <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            accepted_q <= 1'b0;
            digit_q    <= '0;
            dvalid_q   <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            svld_q     <= svld_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            accepted_q <= accepted_d;
            digit_q    <= digit_d;
            dvalid_q   <= dvalid_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign digit_valid = dvalid_q;
    assign frame_done  = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture. The stimulus drives dwells of
// (enables, pattern, length). A dwell of at least STABLE_CYCLES cycles is one
// event that lands STABLE_CYCLES+2 edges after the change. The model applies the
// event rules to an abstract digit/seen/err state and queues timed output
// snapshots and frame pulses. The monitor compares every cycle.
module tb_seven_seg_capture;
    localparam int SC  = 4;
    localparam bit SAL = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a, b, c, d, e, f, g, n3, n2, n1, n0;
    logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
    logic frame_done, err;

    seven_seg_capture #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(SAL)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .n3(n3), .n2(n2), .n1(n1), .n0(n0),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit_valid(digit_valid), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int              cyc;
        bit              is_frame;
        logic [3:0][3:0] dig;
        logic [3:0]      vld;
        logic            err;
    } exp_t;

    exp_t q[$];
    exp_t ex = '{cyc: 0, is_frame: 1'b0, dig: 16'h0, vld: 4'h0, err: 1'b0};

    localparam logic [6:0] TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic [3:0][3:0] m_dig  = '0;
    logic [3:0]      m_vld  = '0;
    logic [3:0]      m_seen = '0;
    logic            m_err  = 1'b0;
    logic [10:0]     cur;
    bit              mon_on = 1'b0;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, expv);
        end
    endtask

    task automatic push_snap(input int t);
        exp_t it;
        it.cyc = t; it.is_frame = 1'b0; it.dig = m_dig; it.vld = m_vld; it.err = m_err;
        q.push_back(it);
    endtask

    // Effect of one stable event at edge t
    task automatic model_event(input int t, input logic [3:0] nen, input logic [6:0] lit);
        logic [3:0] en;
        int idx;
        exp_t it;
        en  = ~nen;
        idx = -1;
        for (int k = 0; k < 16; k++) if (TBL[k] == lit) idx = k;
        if (en != 4'b0) begin
            if ($countones(en) > 1 || idx < 0) begin
                m_err = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (en[i]) begin
                        m_dig[i]  = 4'(idx);
                        m_vld[i]  = 1'b1;
                        m_seen[i] = 1'b1;
                    end
                end
            end
        end
        push_snap(t);
        if (m_seen == 4'hF) begin
            m_seen = 4'h0;
            it.cyc = t + 1; it.is_frame = 1'b1; it.dig = '0; it.vld = '0; it.err = 1'b0;
            q.push_back(it);
        end
    endtask

    task automatic drive(input logic [10:0] s);
        {a, b, c, d, e, f, g, n3, n2, n1, n0} = s;
        cur = s;
    endtask

    task automatic hold(input int len);
        repeat (len) @(negedge clk);
    endtask

    task automatic dwell(input logic [3:0] nen, input logic [6:0] lit, input int len);
        logic [10:0] s;
        s = {(SAL ? ~lit : lit), nen};
        if (s == cur) begin
            // A one-cycle filler keeps back-to-back equal dwells separate.
            drive(cur ^ 11'h1);
            hold(1);
        end
        if (len >= SC) model_event(edge_n + SC + 2, nen, lit);
        drive(s);
        hold(len);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        while (q.size() > 0 && q[$].cyc > edge_n) void'(q.pop_back());
        m_dig = '0; m_vld = '0; m_seen = '0; m_err = 1'b0;
        push_snap(edge_n + 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: applies due scoreboard entries and checks all outputs
    always @(negedge clk) begin
        if (mon_on) begin
            bit exp_frame;
            exp_frame = 1'b0;
            while (q.size() > 0 && q[0].cyc <= edge_n) begin
                exp_t it;
                it = q.pop_front();
                if (it.is_frame) exp_frame = 1'b1;
                else             ex = it;
            end
            chk("digits", 32'({digit3, digit2, digit1, digit0}), 32'(ex.dig));
            chk("digit_valid", 32'(digit_valid), 32'(ex.vld));
            chk("err", 32'(err), 32'(ex.err));
            chk("frame_done", 32'(frame_done), 32'(exp_frame));
        end
    end

    localparam logic [6:0] PAT_A = 7'b1110111;
    localparam logic [6:0] PAT_8 = 7'b1111111;

    initial begin
        drive({(SAL ? 7'h00 : 7'h7F), 4'hF});
        hold(3);
        rst = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        dwell(4'b1110, TBL[1], 10);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                dwell(~(4'b0001 << k), TBL[k + 1], 8);
        dwell(4'b1011, PAT_A, 4);
        dwell(4'b1011, PAT_8, 2);
        dwell(4'b1011, PAT_A, 4);
        dwell(4'b1111, TBL[8], 20);
        dwell(4'b1101, 7'b0000001, 8);
        dwell(4'b1100, TBL[5], 8);

        do_reset();
        dwell(4'b1110, TBL[1], 8);
        dwell(4'b1101, TBL[2], 8);
        do_reset();
        for (int k = 0; k < 4; k++) dwell(~(4'b0001 << k), TBL[k + 1], 8);

        for (int i = 0; i < 160; i++) begin
            logic [3:0] nen;
            logic [6:0] lit;
            int r;
            if (i == 80) do_reset();
            r = $urandom_range(0, 9);
            if (r < 6)      nen = ~(4'b0001 << $urandom_range(0, 3));
            else if (r < 8) nen = 4'hF;
            else            nen = 4'($urandom);
            if ($urandom_range(0, 9) < 8) lit = TBL[$urandom_range(0, 15)];
            else                          lit = 7'($urandom);
            dwell(nen, lit, $urandom_range(1, 10));
        end

        hold(SC + 6);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
